// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared widths and the issue-queue entry record.
// The issue queue stores one iq_entry_t per slot; its field widths are the
// defaults of the generic_issue_queue parameters.
package mips_core_pkg;

    localparam int unsigned IQ_PREG_IDX  = 6;
    localparam int unsigned IQ_AL_IDX    = 6;
    localparam int unsigned IQ_BR_NUM    = 4;
    localparam int unsigned IQ_PAYLOAD_W = 64;

    typedef struct packed {
        logic [IQ_PREG_IDX-1:0]  src1;
        logic [IQ_PREG_IDX-1:0]  src2;
        logic                    src1_rdy;
        logic                    src2_rdy;
        logic [IQ_AL_IDX-1:0]    al_id;
        logic [IQ_BR_NUM-1:0]    br_mask;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// iq_age_matrix: relative-age tracking for the issue queue.
//   clk, rst : clock, synchronous active-high reset
//   valid    : entries currently holding an op
//   alloc    : entries written with a new op this cycle
//   free     : entries leaving this cycle (issue or squash)
//   req      : eligible entries
//   grant    : one-hot oldest eligible entry
// older_q[i][j] = 1 means entry j is older than entry i.
module iq_age_matrix #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    // Columns of freed and re-allocated entries are cleared so stale bits
    // never make a newly written entry look older than a survivor.
    // Within one group, lower entry index comes from the lower slot.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            older_d[i] = older_q[i] & ~(free | alloc);
            if (alloc[i]) begin
                older_d[i] = valid & ~free;
                for (int unsigned j = 0; j < i; j++) begin
                    if (alloc[j]) older_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) older_q[i] <= '0;
            else     older_q[i] <= older_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && ((older_q[i] & req) == '0);
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// priority_encoder: one-hot grant of the lowest-index set request bit.
//   req : request vector
//   gnt : one-hot grant (all zero when no request)
module priority_encoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && (gnt == '0)) gnt[i] = 1'b1;
        end
    end

endmodule

// File: rtl/generic_issue_queue.sv
// generic_issue_queue: out-of-order issue queue with wakeup, oldest-first
// select, issue lock and branch-mask squash.
//   clk, rst            : clock, synchronous active-high reset
//   disp_*              : DISP_W-wide dispatch group, disp_ready = room for it
//   wb_valid, wb_preg   : wakeup tag broadcast
//   iss_*               : issue port (valid/ready handshake)
//   br_valid/tag/mispr. : branch resolution (clear or squash by mask bit)
//   occupancy           : number of valid entries
module generic_issue_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned PREG_IDX  = IQ_PREG_IDX,
    parameter int unsigned AL_IDX    = IQ_AL_IDX,
    parameter int unsigned BR_NUM    = IQ_BR_NUM,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DISP_W-1:0]             disp_valid,
    input  logic [DISP_W*PREG_IDX-1:0]    disp_src1,
    input  logic [DISP_W*PREG_IDX-1:0]    disp_src2,
    input  logic [DISP_W-1:0]             disp_src1_rdy,
    input  logic [DISP_W-1:0]             disp_src2_rdy,
    input  logic [DISP_W*AL_IDX-1:0]      disp_al_id,
    input  logic [DISP_W*BR_NUM-1:0]      disp_br_mask,
    input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
    output logic                          disp_ready,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*PREG_IDX-1:0]  wb_preg,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [PREG_IDX-1:0]           iss_src1,
    output logic [PREG_IDX-1:0]           iss_src2,
    output logic [AL_IDX-1:0]             iss_al_id,
    output logic [BR_NUM-1:0]             iss_br_mask,
    output logic [PAYLOAD_W-1:0]          iss_payload,
    input  logic                          br_valid,
    input  logic [$clog2(BR_NUM)-1:0]     br_tag,
    input  logic                          br_mispredict,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    iq_entry_t        entry_q [DEPTH];
    iq_entry_t        entry_d [DEPTH];
    logic             lock_q;
    logic [DEPTH-1:0] lock_sel_q;

    logic [DEPTH-1:0] eligible, grant, sel, squash_vec, free_vec, written;
    logic [DISP_W-1:0]            slot_take;
    logic [DISP_W-1:0][DEPTH-1:0] alloc_oh;
    logic [DISP_W-1:0][DEPTH-1:0] write_oh;
    iq_entry_t        new_entry [DISP_W];
    iq_entry_t        picked;
    logic             sel_any, fire;

    function automatic logic wb_hit(input logic [PREG_IDX-1:0] tag,
                                    input logic [WB_PORTS-1:0] wv,
                                    input logic [WB_PORTS*PREG_IDX-1:0] wp);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wv[p] && (wp[p*PREG_IDX +: PREG_IDX] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign disp_ready = (32'(occupancy) + DISP_W) <= DEPTH;

    always_comb begin
        for (int unsigned k = 0; k < DISP_W; k++) begin
            slot_take[k] = disp_ready && disp_valid[k];
        end
    end

    // Lowest free entries, slot 0 first; an invalid slot consumes nothing.
    for (genvar k = 0; k < DISP_W; k++) begin : g_alloc
        logic [DEPTH-1:0] avail;
        logic [DEPTH-1:0] gnt;
        if (k == 0) begin : g_head
            assign avail = ~valid_q;
        end else begin : g_tail
            assign avail = g_alloc[k-1].avail & ~(slot_take[k-1] ? g_alloc[k-1].gnt : '0);
        end
        priority_encoder #(.WIDTH(DEPTH)) u_pe (.req(avail), .gnt(gnt));
        assign alloc_oh[k] = gnt;
    end

    always_comb begin
        written = '0;
        for (int unsigned k = 0; k < DISP_W; k++) begin
            logic [BR_NUM-1:0] m;
            m = disp_br_mask[k*BR_NUM +: BR_NUM];
            new_entry[k].src1     = disp_src1[k*PREG_IDX +: PREG_IDX];
            new_entry[k].src2     = disp_src2[k*PREG_IDX +: PREG_IDX];
            new_entry[k].src1_rdy = disp_src1_rdy[k] ||
                                    wb_hit(disp_src1[k*PREG_IDX +: PREG_IDX], wb_valid, wb_preg);
            new_entry[k].src2_rdy = disp_src2_rdy[k] ||
                                    wb_hit(disp_src2[k*PREG_IDX +: PREG_IDX], wb_valid, wb_preg);
            new_entry[k].al_id    = disp_al_id[k*AL_IDX +: AL_IDX];
            new_entry[k].payload  = disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
            new_entry[k].br_mask  = m;
            if (br_valid && !br_mispredict) new_entry[k].br_mask[br_tag] = 1'b0;
            // A dispatching op on the mispredicted path is accepted but dropped.
            write_oh[k] = (slot_take[k] && !(br_valid && br_mispredict && m[br_tag]))
                          ? alloc_oh[k] : '0;
            written = written | write_oh[k];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i]   = valid_q[i] && entry_q[i].src1_rdy && entry_q[i].src2_rdy;
            squash_vec[i] = valid_q[i] && br_valid && br_mispredict && entry_q[i].br_mask[br_tag];
        end
    end

    iq_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk   (clk),
        .rst   (rst),
        .valid (valid_q),
        .alloc (written),
        .free  (free_vec),
        .req   (eligible),
        .grant (grant)
    );

    assign sel = lock_q ? lock_sel_q : grant;

    always_comb begin
        picked  = '0;
        sel_any = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                picked  = entry_q[i];
                sel_any = 1'b1;
            end
        end
    end

    // A squash hitting the selected op pulls iss_valid down in the same cycle.
    assign iss_valid   = sel_any && !(br_valid && br_mispredict && picked.br_mask[br_tag]);
    assign iss_src1    = picked.src1;
    assign iss_src2    = picked.src2;
    assign iss_al_id   = picked.al_id;
    assign iss_br_mask = picked.br_mask;
    assign iss_payload = picked.payload;

    assign fire     = iss_valid && iss_ready;
    assign free_vec = (fire ? sel : '0) | squash_vec;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (wb_hit(entry_q[i].src1, wb_valid, wb_preg)) entry_d[i].src1_rdy = 1'b1;
            if (wb_hit(entry_q[i].src2, wb_valid, wb_preg)) entry_d[i].src2_rdy = 1'b1;
            if (br_valid && !br_mispredict) entry_d[i].br_mask[br_tag] = 1'b0;
        end
        valid_d = valid_q & ~free_vec;
        for (int unsigned k = 0; k < DISP_W; k++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (write_oh[k][i]) begin
                    entry_d[i] = new_entry[k];
                    valid_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            valid_q    <= valid_d;
            lock_q     <= iss_valid && !iss_ready;
            lock_sel_q <= sel;
            for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: doc/generic_issue_queue.md
GENERIC_ISSUE_QUEUE -- requirements
Module: generic_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of queue entries (power of 2, >=4).
REQ-002 SHALL have parameter DISP_W, default 2: dispatch slots per cycle.
REQ-003 SHALL have parameter WB_PORTS, default 2: wakeup (write-back) broadcast ports.
REQ-004 SHALL have parameter PREG_IDX, default 6: physical register index width.
REQ-005 SHALL have parameter AL_IDX, default 6: active-list id width.
REQ-006 SHALL have parameter BR_NUM, default 4: in-flight branch tags; branch mask width.
REQ-007 SHALL have parameter PAYLOAD_W, default 64: opaque per-op payload (alu_ctl, immediate, prediction, recovery target).
REQ-008 SHALL have clk  in  1: the one clock; all state updates on posedge.
REQ-009 SHALL have rst  in  1: synchronous reset, active-high.
REQ-010 SHALL have disp_valid  in  DISP_W, disp_src1/disp_src2  in  DISP_W*PREG_IDX, disp_src1_rdy/disp_src2_rdy  in  DISP_W, disp_al_id  in  DISP_W*AL_IDX, disp_br_mask  in  DISP_W*BR_NUM, disp_payload  in  DISP_W*PAYLOAD_W: dispatch inputs.
REQ-011 SHALL have disp_ready  out  1: queue accepts this cycle's dispatch group.
REQ-012 SHALL have wb_valid  in  WB_PORTS, wb_preg  in  WB_PORTS*PREG_IDX: wakeup tags.
REQ-013 SHALL have iss_valid  out  1, iss_ready  in  1, iss_src1/iss_src2  out  PREG_IDX, iss_al_id  out  AL_IDX, iss_br_mask  out  BR_NUM, iss_payload  out  PAYLOAD_W: issue port.
REQ-014 SHALL have br_valid  in  1, br_tag  in  clog2(BR_NUM), br_mispredict  in  1: branch resolution.
REQ-015 SHALL have occupancy  out  clog2(DEPTH+1): valid-entry count.

Function
REQ-016 disp_ready SHALL be 1 iff free entries >= DISP_W, computed from registered state only; the group is accepted all-or-nothing when disp_ready=1, and slots with disp_valid=0 are skipped.
REQ-017 Accepted ops SHALL be written to lowest-index free entries, slot 0 to the lowest; entries are valid the next cycle.
REQ-018 Each entry SHALL store src ready bits; a wb_valid tag matching a stored src SHALL set its ready bit next cycle; tags matching dispatching srcs in the same cycle SHALL be captured as ready (same-cycle bypass).
REQ-019 An entry SHALL be eligible when valid and both ready bits set; select SHALL pick the oldest eligible entry via age matrix; within one dispatch group, lower slot is older.
REQ-020 iss_valid/iss_* SHALL be combinational from state; once iss_valid=1 with iss_ready=0, the selected entry SHALL be locked and outputs held stable until handshake or squash.
REQ-021 On iss_valid&&iss_ready the entry SHALL be freed next cycle; a freed slot is not reusable in the same cycle.
REQ-022 On br_valid&&!br_mispredict, bit br_tag SHALL be cleared in every entry mask and in accepted dispatch masks.
REQ-023 On br_valid&&br_mispredict, every entry (and accepted dispatch op) with bit br_tag set SHALL be invalidated next cycle; if the locked entry is squashed, iss_valid SHALL drop that cycle and the lock releases.
REQ-024 occupancy SHALL equal previous + accepted dispatches - issue handshake - squashed entries, never exceeding DEPTH.
REQ-025 Simultaneous dispatch, wakeup, issue and squash in one cycle SHALL all take effect; squash overrides wakeup for the same entry.

Reset
REQ-026 While rst=1 at posedge: all entries invalid, ready bits, masks and age matrix cleared, lock released; outputs next cycle: iss_valid=0, occupancy=0, disp_ready=1.
REQ-027 Reset mid-operation SHALL discard all contents; dispatch and wakeup in the reset cycle SHALL be ignored.

Structure
REQ-028 Entry struct type (src tags, ready bits, al_id, br_mask, payload) and width constants SHALL live in mips_core_pkg.
REQ-029 Free-slot allocation SHALL reuse the existing priority_encoder; oldest-ready selection SHALL be a sub-module iq_age_matrix (DEPTH x DEPTH, row set on allocate, column cleared on free).

Verification
REQ-030 DEPTH=8, DISP_W=2: dispatch 4 groups of 2 with ready srcs, iss_ready=0 -> occupancy=8, disp_ready=0; 5th group ignored.
REQ-031 Dispatch op A src1=p5 not ready, then B ready; wb p5 -> B issues first, A issues the cycle after wakeup.
REQ-032 Dispatch group with src=p9 while wb p9 the same cycle -> op eligible next cycle, iss_valid=1.
REQ-033 iss_valid=1, iss_ready=0 for 3 cycles while an older op wakes -> outputs unchanged until handshake.
REQ-034 Entries with masks 0001, 0010, 0011; br_valid, br_tag=0, br_mispredict=1 -> only 0010 remains, occupancy=1; locked squashed op drops iss_valid.
REQ-035 Full queue, rst=1 for 1 cycle alongside dispatch -> occupancy=0, iss_valid=0, disp_ready=1.
